// File: rtl/pellet_tracker_if.sv
// Bundles the pellet_tracker game inputs (positions, pellet table, pulses) and
// the game-state outputs consumed by color_mapper and the movement blocks.
interface pellet_tracker_if #(
  parameter int unsigned NUM_DOTS = 32
);
  logic                frame_tick;
  logic                restart;
  logic [9:0]          BallX;
  logic [9:0]          BallY;
  logic [9:0]          Ball_size;
  logic [9:0]          redghostX;
  logic [9:0]          redghostY;
  logic [9:0]          dX [NUM_DOTS];
  logic [9:0]          dY [NUM_DOTS];
  logic [9:0]          score;
  logic [3:0]          fruits;
  logic [7:0]          lives;
  logic [NUM_DOTS-1:0] dots_left;
  logic [2:0]          game_state;
  logic                respawn;

  // Driver of positions/pulses, reader of game state
  modport master (
    output frame_tick, restart, BallX, BallY, Ball_size, redghostX, redghostY, dX, dY,
    input  score, fruits, lives, dots_left, game_state, respawn
  );

  // The tracker itself
  modport slave (
    input  frame_tick, restart, BallX, BallY, Ball_size, redghostX, redghostY, dX, dY,
    output score, fruits, lives, dots_left, game_state, respawn
  );
endinterface

// File: rtl/pellet_tracker.sv
// pellet_tracker: per-frame pellet/fruit eating scan, ghost collision and the
// play/death/game-over/win state machine feeding color_mapper.
// Optional feature macro: PELLET_TRACKER_EXTRA_LIFE_EN (one bonus life when the
// score first crosses EXTRA_LIFE_SCORE).
module pellet_tracker #(
  parameter int unsigned NUM_DOTS     = 32,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned DOT_POINTS   = 1,
  parameter int unsigned FRUIT_POINTS = 10,
  parameter int unsigned SCORE_MAX    = 999,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned GHOST_HIT    = 12
`ifdef PELLET_TRACKER_EXTRA_LIFE_EN
  ,
  parameter int unsigned EXTRA_LIFE_SCORE = 200
`endif
) (
  input logic             Clk,
  input logic             Reset,
  pellet_tracker_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_DOTS + 6);
  localparam int unsigned DotW = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
  localparam int unsigned CntW = $clog2(DEATH_FRAMES + 1);

  localparam logic [IdxW-1:0] FirstFruit = IdxW'(NUM_DOTS);
  localparam logic [IdxW-1:0] LastItem   = IdxW'(NUM_DOTS + 3);
  localparam logic [IdxW-1:0] EvalIdx    = IdxW'(NUM_DOTS + 4);
  localparam logic [CntW-1:0] DeathLast  = CntW'(DEATH_FRAMES - 1);
  localparam logic [10:0]     DotPts     = 11'(DOT_POINTS);
  localparam logic [10:0]     FruitPts   = 11'(FRUIT_POINTS);
  localparam logic [10:0]     ScoreMax   = 11'(SCORE_MAX);
  localparam logic [10:0]     GhostHit   = 11'(GHOST_HIT);
  localparam logic [7:0]      StartLives = 8'(START_LIVES);
`ifdef PELLET_TRACKER_EXTRA_LIFE_EN
  localparam logic [10:0]     XLifeScore = 11'(EXTRA_LIFE_SCORE);
`endif

  // Encoding is visible on game_state
  typedef enum logic [2:0] {
    StPlay  = 3'd0,
    StScan  = 3'd1,
    StDeath = 3'd2,
    StOver  = 3'd3,
    StWin   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [9:0]          bx_q, bx_d, by_q, by_d, bs_q, bs_d, gx_q, gx_d, gy_q, gy_d;
  logic [9:0]          score_q, score_d;
  logic [3:0]          fruits_q, fruits_d;
  logic [7:0]          lives_q, lives_d;
  logic [NUM_DOTS-1:0] dots_q, dots_d;
  logic                win_q, win_d, hit_q, hit_d;
  logic                respawn_q, respawn_d;
`ifdef PELLET_TRACKER_EXTRA_LIFE_EN
  logic                bonus_q, bonus_d;
`endif

  logic [DotW-1:0] dot_sel;
  logic [1:0]      fruit_sel;
  logic [9:0]      fx_lo, fx_hi, fy_lo, fy_hi;
  logic            item_hit;
  logic [10:0]     item_pts;
  logic [10:0]     sum;

  function automatic logic [10:0] absdiff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign dot_sel   = idx_q[DotW-1:0];
  assign fruit_sel = 2'(idx_q - FirstFruit);

  // Inclusive bounding box of the fruit under test
  always_comb begin
    fx_lo = '0;
    fx_hi = '0;
    fy_lo = '0;
    fy_hi = '0;
    unique case (fruit_sel)
      2'd0: begin fx_lo = 10'd12;  fx_hi = 10'd38;  fy_lo = 10'd10;  fy_hi = 10'd35;  end
      2'd1: begin fx_lo = 10'd372; fx_hi = 10'd396; fy_lo = 10'd10;  fy_hi = 10'd34;  end
      2'd2: begin fx_lo = 10'd12;  fx_hi = 10'd38;  fy_lo = 10'd414; fy_hi = 10'd439; end
      2'd3: begin fx_lo = 10'd370; fx_hi = 10'd396; fy_lo = 10'd413; fy_hi = 10'd439; end
    endcase
  end

  // Next-state: frame latch, one-item-per-clock scan, resolve, death timer, restart
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    bx_d      = bx_q;
    by_d      = by_q;
    bs_d      = bs_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    score_d   = score_q;
    fruits_d  = fruits_q;
    lives_d   = lives_q;
    dots_d    = dots_q;
    win_d     = win_q;
    hit_d     = hit_q;
    respawn_d = 1'b0;
`ifdef PELLET_TRACKER_EXTRA_LIFE_EN
    bonus_d   = bonus_q;
`endif
    item_hit  = 1'b0;
    item_pts  = '0;
    sum       = '0;

    unique case (state_q)
      StPlay: begin
        if (bus.frame_tick) begin
          bx_d    = bus.BallX;
          by_d    = bus.BallY;
          bs_d    = bus.Ball_size;
          gx_d    = bus.redghostX;
          gy_d    = bus.redghostY;
          idx_d   = '0;
          state_d = StScan;
        end
      end

      StScan: begin
        idx_d = idx_q + 1'b1;
        if (idx_q < FirstFruit) begin
          if (!dots_q[dot_sel] &&
              absdiff({1'b0, bx_q}, {1'b0, bus.dX[dot_sel]} + 11'd2) <= {1'b0, bs_q} &&
              absdiff({1'b0, by_q}, {1'b0, bus.dY[dot_sel]} + 11'd2) <= {1'b0, bs_q}) begin
            dots_d[dot_sel] = 1'b1;
            item_hit        = 1'b1;
            item_pts        = DotPts;
          end
        end else if (idx_q <= LastItem) begin
          if (!fruits_q[fruit_sel] && bx_q >= fx_lo && bx_q <= fx_hi &&
              by_q >= fy_lo && by_q <= fy_hi) begin
            fruits_d[fruit_sel] = 1'b1;
            item_hit            = 1'b1;
            item_pts            = FruitPts;
          end
        end else if (idx_q == EvalIdx) begin
          win_d = (&dots_q) && (&fruits_q);
          hit_d = absdiff({1'b0, bx_q}, {1'b0, gx_q}) <= GhostHit &&
                  absdiff({1'b0, by_q}, {1'b0, gy_q}) <= GhostHit;
        end else begin
          idx_d = '0;
          if (win_q) begin
            state_d = StWin;
          end else if (hit_q) begin
            lives_d = (lives_q != 8'd0) ? (lives_q - 8'd1) : 8'd0;
            if (lives_q <= 8'd1) begin
              state_d = StOver;
            end else begin
              state_d = StDeath;
              cnt_d   = '0;
            end
          end else begin
            state_d = StPlay;
          end
        end

        if (item_hit) begin
          sum     = {1'b0, score_q} + item_pts;
          score_d = (sum > ScoreMax) ? ScoreMax[9:0] : sum[9:0];
`ifdef PELLET_TRACKER_EXTRA_LIFE_EN
          // Bonus lands during the scan, so it always precedes a ghost-hit decrement
          if (!bonus_q && ({1'b0, score_q} < XLifeScore) &&
              ({1'b0, score_d} >= XLifeScore)) begin
            bonus_d = 1'b1;
            lives_d = (lives_q == 8'hFF) ? 8'hFF : (lives_q + 8'd1);
          end
`endif
        end
      end

      StDeath: begin
        if (bus.frame_tick) begin
          if (cnt_q == DeathLast) begin
            cnt_d     = '0;
            respawn_d = 1'b1;
            state_d   = StPlay;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StOver, StWin: begin
        if (bus.restart) begin
          score_d   = '0;
          fruits_d  = '0;
          lives_d   = StartLives;
          dots_d    = '0;
          idx_d     = '0;
          cnt_d     = '0;
          respawn_d = 1'b1;
          state_d   = StPlay;
`ifdef PELLET_TRACKER_EXTRA_LIFE_EN
          bonus_d   = 1'b0;
`endif
        end
      end

      default: state_d = StPlay;
    endcase
  end

  // State register; reset aborts any scan in progress
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StPlay;
      idx_q     <= '0;
      cnt_q     <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      bs_q      <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      score_q   <= '0;
      fruits_q  <= '0;
      lives_q   <= StartLives;
      dots_q    <= '0;
      win_q     <= 1'b0;
      hit_q     <= 1'b0;
      respawn_q <= 1'b0;
`ifdef PELLET_TRACKER_EXTRA_LIFE_EN
      bonus_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      bs_q      <= bs_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      score_q   <= score_d;
      fruits_q  <= fruits_d;
      lives_q   <= lives_d;
      dots_q    <= dots_d;
      win_q     <= win_d;
      hit_q     <= hit_d;
      respawn_q <= respawn_d;
`ifdef PELLET_TRACKER_EXTRA_LIFE_EN
      bonus_q   <= bonus_d;
`endif
    end
  end

  assign bus.score      = score_q;
  assign bus.fruits     = fruits_q;
  assign bus.lives      = lives_q;
  assign bus.dots_left  = dots_q;
  assign bus.game_state = state_q;
  assign bus.respawn    = respawn_q;

endmodule
